// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and bridge state type shared by the master bridge
`ifndef AHB_BUS_WIDTH
`define AHB_BUS_WIDTH 32
`endif

package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data access, privileged, non-bufferable, non-cacheable.
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR2,
    ST_MISAL
  } bridge_state_t;

  // Size 3 (double word) is not supported on this bus and is treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
    logic mis;
    case ({1'b0, size})
      HSIZE_BYTE: mis = 1'b0;
      HSIZE_HALF: mis = addr_lsb[0];
      HSIZE_WORD: mis = (addr_lsb != 2'b00);
      default:    mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ahb_master_bridge_if.sv
// rtl/ahb_master_bridge_if.sv - core request/response and AHB-Lite master signal bundle
interface ahb_master_bridge_if #(
  parameter int AW = 32,
  parameter int DW = `AHB_BUS_WIDTH
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [1:0]    req_size;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;

  modport master (
    input  req_valid, req_addr, req_write, req_size, req_wdata, HRDATA, HREADY, HRESP,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );

  modport slave (
    output req_valid, req_addr, req_write, req_size, req_wdata, HRDATA, HREADY, HRESP,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/ahb_wait_timer.sv
// rtl/ahb_wait_timer.sv - wait-state counter with clear/enable/expire, built only with AHB_MST_TIMEOUT_EN
`ifdef AHB_MST_TIMEOUT_EN
module ahb_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  logic [7:0] count_q, count_d;

  // Clear wins over counting; the count holds when neither is asserted.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'd0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the LIMIT-th consecutive wait cycle so the response follows immediately.
  assign expire_o = enable_i && !clear_i && (count_q == 8'(LIMIT - 1));
endmodule
`endif

// File: rtl/ahb_master_bridge.sv
// rtl/ahb_master_bridge.sv - single-outstanding AHB-Lite master; wait timeout under AHB_MST_TIMEOUT_EN
module ahb_master_bridge
  import ahb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = `AHB_BUS_WIDTH
`ifdef AHB_MST_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input logic                 HCLK,
  input logic                 HRST_N,
  ahb_master_bridge_if.master bus
);

  bridge_state_t state_q, state_d;
  htrans_t       htrans_q, htrans_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic          hwrite_q, hwrite_d;
  logic [2:0]    hsize_q, hsize_d;
  logic [DW-1:0] hwdata_q, hwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          req_ready_q, req_ready_d;
  logic          accept;
  logic          tmr_expire;

  assign accept = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;

`ifdef AHB_MST_TIMEOUT_EN
  logic tmr_clear, tmr_en;
  assign tmr_clear = accept || ((state_q == ST_ADDR) && bus.HREADY);
  assign tmr_en    = !bus.HREADY &&
                     ((state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_ERR2));

  ahb_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .clk_i    (HCLK),
    .rst_ni   (HRST_N),
    .clear_i  (tmr_clear),
    .enable_i (tmr_en),
    .expire_o (tmr_expire)
  );
`else
  assign tmr_expire = 1'b0;
`endif

  // Next-state and registered-output decode; responses are pulses, address-phase fields hold.
  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    req_ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          haddr_d     = bus.req_addr;
          hwrite_d    = bus.req_write;
          hsize_d     = {1'b0, bus.req_size};
          hwdata_d    = bus.req_wdata;
          req_ready_d = 1'b0;
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            state_d     = ST_MISAL;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = ST_ADDR;
            htrans_d = HTRANS_NONSEQ;
          end
        end
      end
      ST_ADDR: begin
        if (bus.HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
        end
      end
      ST_DATA: begin
        if (bus.HREADY) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (bus.HRESP != HRESP_OKAY);
          rsp_rdata_d = (hwrite_q || bus.HRESP == HRESP_ERROR) ? '0 : bus.HRDATA;
        end else if (bus.HRESP == HRESP_ERROR) begin
          state_d = ST_ERR2;
        end
      end
      ST_ERR2: begin
        if (bus.HREADY) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ST_MISAL: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // A stalled slave is abandoned; anything it returns later lands while IDLE and is ignored.
    if (tmr_expire) begin
      state_d     = ST_IDLE;
      htrans_d    = HTRANS_IDLE;
      req_ready_d = 1'b1;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end
  end

  // State and output registers; reset drops any in-flight transfer silently.
  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      state_q     <= ST_IDLE;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HWDATA    = hwdata_q;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_DEFAULT;

endmodule
